// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state encoding for the 8-requester round-robin arbiter
package arb_pkg;

  localparam int NREQ         = 8;
  localparam int ID_W         = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - combinational 8-bit MSB-first priority encoder
module prio_enc8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] in,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  always_comb begin
    idx = '0;
    any = |in;
    // Ascending scan: the last (highest) set bit wins.
    for (int i = 0; i < NREQ; i++) begin
      if (in[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/eight_req_rr_arbiter.sv
// rtl/eight_req_rr_arbiter.sv - 8-way round-robin arbiter with grant lock
module eight_req_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;

    logic [NREQ-1:0] req_rot;
    logic [ID_W-1:0] enc_idx;
    logic            enc_any;
    logic [ID_W-1:0] win_id;
    logic            revoke;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        req_rot = '0;
        for (int j = 0; j < NREQ; j++) begin
            req_rot[j] = req[ID_W'(j) + ptr_q + 3'd1];
        end
    end

    prio_enc8 u_enc (
        .in  (req_rot),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign win_id = enc_idx + ptr_q + 3'd1;

`ifdef ARB_TIMEOUT_EN
    assign revoke = (hold_cnt_q == HOLD_LAST);
`else
    assign revoke = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    state_d  = ST_GRANT;
                    gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
                    gnt_id_d = win_id;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!req[gnt_id_q] || revoke) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    ptr_d    = gnt_id_q - 3'd1;
`ifdef ARB_TIMEOUT_EN
                    timeout_d = req[gnt_id_q];
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = hold_cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= ID_W'(NREQ - 1);
            gnt_q    <= '0;
            gnt_id_q <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_eight_req_rr_arbiter.sv
// tb/tb_eight_req_rr_arbiter.sv - directed self-checking bench for eight_req_rr_arbiter
module tb_eight_req_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eight_req_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                              input logic v, input logic to);
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
        check({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
        check({tag, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order [4] = '{7, 6, 7, 6};
        logic [7:0] onehot;

        rst = 1'b1;
        req = 8'hFF;
        tick();
        expect_out("rst1", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out("rst2", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        req = 8'h00;
        tick();
        expect_out("idle", 8'h00, 3'd0, 1'b0, 1'b0);

        req = 8'b0001_0010;
        tick();
        expect_out("prio_win4", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
        tick();
        expect_out("prio_hold4", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
        req = 8'b0000_0010;
        tick();
        expect_out("prio_bubble", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out("prio_win1", 8'b0000_0010, 3'd1, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        expect_out("prio_rel1", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();

        req = 8'b1100_0000;
        for (int i = 0; i < 4; i++) begin
            onehot = 8'd1 << order[i];
            tick();
            expect_out($sformatf("rot%0d_gnt", i), onehot, 3'(order[i]), 1'b1, 1'b0);
            tick();
            tick();
            check($sformatf("rot%0d_hold", i), 32'(gnt), 32'(onehot));
            req = 8'b1100_0000 & ~onehot;
            tick();
            expect_out($sformatf("rot%0d_bubble", i), 8'h00, 3'd0, 1'b0, 1'b0);
            req = 8'b1100_0000;
        end
        req = 8'h00;
        tick();
        expect_out("rot_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        req = 8'b0000_1000;
        tick();
        expect_out("npre_win3", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
        req = 8'b1000_1000;
        tick();
        expect_out("npre_hold_a", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
        tick();
        expect_out("npre_hold_b", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
        req = 8'b1000_0000;
        tick();
        expect_out("npre_bubble", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out("npre_win7", 8'b1000_0000, 3'd7, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        tick();

        req = 8'b0000_0001;
        tick();
        expect_out("to_win0", 8'h01, 3'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int i = 2; i <= 4; i++) begin
            tick();
            expect_out($sformatf("to_c%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
        end
        tick();
        expect_out("to_revoke", 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        expect_out("to_regrant", 8'h01, 3'd0, 1'b1, 1'b0);
`else
        for (int i = 2; i <= 9; i++) begin
            tick();
            expect_out($sformatf("nolimit_c%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
        end
`endif
        req = 8'h00;
        tick();
        expect_out("to_release", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();

        req = 8'b0100_0000;
        tick();
        expect_out("mr_win6a", 8'b0100_0000, 3'd6, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        req = 8'b0100_0000;
        tick();
        expect_out("mr_win6b", 8'b0100_0000, 3'd6, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        expect_out("mr_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        req = 8'b0110_0001;
        tick();
        expect_out("mr_after", 8'b0100_0000, 3'd6, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
